alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter N, default 16: operand/result width in bits.
REQ-002 Parameter SEL_LINE, default 4: opcode width in bits.
REQ-003 One clock; reset is synchronous and active-high. Ports are named clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  requester presents an operation.
REQ-007 in_ready  output  1  controller accepts an operation; it is high only in IDLE.
REQ-008 opcode  input  SEL_LINE  0=ADD, 1=SUB, 2=MUL, 3=DIV, 4=AND, 5=OR, 6=XOR, 7..15 illegal.
REQ-009 rs1_val, rs2_val  input  N each  source operands.
REQ-010 rd_addr  input  4  destination register index.
REQ-011 wb_valid  output  1  writeback result is available.
REQ-012 wb_ready  input  1  register file accepts the writeback.
REQ-013 wb_rd  output  4  registered rd_addr of the operation.
REQ-014 wb_data  output  N  registered result.
REQ-015 wb_err  output  1  operation was illegal; qualified by wb_valid.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, EXEC, DIV, WB.
REQ-018 IDLE: if in_valid is high, capture opcode, operands and rd_addr, then go to EXEC.
REQ-019 EXEC, single-cycle ops: compute the result, register it into wb_data, go to WB.
REQ-020 EXEC, DIV: start the divider, go to DIV.
REQ-021 EXEC, illegal op: set wb_data=0 and wb_err=1, go to WB.
REQ-022 ADD and SUB are modulo 2^N and discard the carry/borrow; MUL returns the low N bits of the unsigned product.
REQ-023 DIV is unsigned and returns the quotient.
REQ-024 DIV by zero returns all ones and sets wb_err=0.
REQ-025 DIV stays in the DIV state exactly N cycles, then loads the quotient into wb_data and goes to WB.
REQ-026 WB: wb_valid=1, and wb_data/wb_rd/wb_err are held stable until wb_ready; on wb_valid&&wb_ready, go to IDLE.
REQ-027 Latency from the accept edge T: wb_valid is first high at T+2 for single-cycle or illegal ops, and at T+N+2 for DIV.
REQ-028 There is no back-to-back accept: in_ready=0 from the accept until the cycle after the WB handshake.
REQ-029 in_valid is ignored outside IDLE; input changes after accept do not affect the result.
REQ-030 Outputs never change while wb_valid=1 and wb_ready=0; backpressure is unbounded.

Reset
REQ-031 On rst, the FSM goes to IDLE; in_ready becomes 1 in the first cycle after rst deasserts.
REQ-032 On rst, wb_valid, wb_data, wb_rd, wb_err and busy are all 0.
REQ-033 rst mid-EXEC, mid-DIV or mid-WB aborts the operation: no wb_valid for it, and the divider is cleared.

Configuration
REQ-034 Macro ALU_DIV_EN: when defined, the divider sub-module is instantiated and opcode 3 behaves per REQ-023..REQ-025.
REQ-035 When ALU_DIV_EN is undefined: no divider logic, the DIV state is unreachable, and opcode 3 is treated as illegal (wb_data=0, wb_err=1, latency T+2).

Structure
REQ-036 Package alu_pkg holds the opcode enum, the FSM state enum, and the constants N_DEF=16 and SEL_DEF=4.
REQ-037 Sub-module alu_div_iter is an N-cycle restoring divider.
REQ-038 alu_div_iter has ports clk, rst, start, dividend, divisor, done and quotient.

Verification
REQ-039 ADD, in_valid with rs1=0xFFFF, rs2=0x0001 -> wb_valid at T+2, wb_data=0x0000, wb_err=0.
REQ-040 SUB 0x0003-0x0005 -> wb_data=0xFFFE; MUL 0x0100*0x0100 -> wb_data=0x0000; XOR 0xA5A5^0xFFFF -> wb_data=0x5A5A.
REQ-041 DIV 0x0064/0x0007 -> wb_data=0x000E at T+18; DIV 0x1234/0x0000 -> wb_data=0xFFFF, wb_err=0. Without ALU_DIV_EN: wb_err=1, wb_data=0 at T+2.
REQ-042 Opcode 0xF, rd_addr=5 -> wb_valid at T+2 with wb_rd=5, wb_err=1, wb_data=0.
REQ-043 Hold wb_ready=0 for 10 cycles in WB -> outputs stable, in_ready=0; wb_ready=1 -> IDLE next cycle, next op accepted.
REQ-044 Assert rst at cycle 5 of a DIV -> next cycle IDLE, all outputs 0, no wb_valid; a fresh ADD 2+3 then yields wb_data=0x0005.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and defaults for the ALU issue controller.
//   opcode_e - operation encoding presented on opcode (values 7..15 are illegal)
//   state_e  - issue FSM states
//   N_DEF    - default operand/result width
//   SEL_DEF  - default opcode width
package alu_pkg;

  localparam int N_DEF   = 16;
  localparam int SEL_DEF = 4;

  typedef enum logic [SEL_DEF-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DIV  = 2'd2,
    S_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/alu_div_iter.sv
// alu_div_iter: N-cycle unsigned restoring divider.
// The first quotient bit is resolved on the start edge itself, so the quotient
// is complete N edges after start and done pulses for one cycle right after.
// Divide by zero falls out naturally as an all-ones quotient.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset, clears any division in flight
//   start    in   load operands and begin (ignored state is overwritten)
//   dividend in   N-bit numerator
//   divisor  in   N-bit denominator
//   done     out  one-cycle pulse, quotient valid while high
//   quotient out  N-bit result (holds until the next start)
// N must be at least 2.
module alu_div_iter
  import alu_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         done,
  output logic [N-1:0] quotient
);

  localparam int CNT_W = $clog2(N + 1);

  logic [N-1:0]     rem_q, quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             active_q;
  logic             done_q;

  logic [N-1:0] rem_src, quo_src, rem_nx, quo_nx;
  logic [N:0]   trial, diff;
  logic         q_bit;

  // One restoring step; on start the step runs on the fresh operands.
  always_comb begin
    rem_src = start ? '0 : rem_q;
    quo_src = start ? dividend : quo_q;
    trial   = {rem_src, quo_src[N-1]};
    diff    = trial - {1'b0, divisor};
    q_bit   = (trial >= {1'b0, divisor});
    rem_nx  = q_bit ? diff[N-1:0] : trial[N-1:0];
    quo_nx  = {quo_src[N-2:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q    <= rem_nx;
        quo_q    <= quo_nx;
        cnt_q    <= CNT_W'(N - 1);
        active_q <= 1'b1;
      end else if (active_q) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-issue ALU controller with registered writeback.
// Accepts one operation in IDLE, executes it (single cycle, or iterative
// divide), then presents the result until the register file takes it.
// Build option: define ALU_DIV_EN to include the divider; without it opcode 3
// is reported as illegal and the DIV state is never entered.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready request handshake (ready only in IDLE)
//   opcode            operation select
//   rs1_val, rs2_val  operands
//   rd_addr           destination register index
//   wb_valid/wb_ready writeback handshake
//   wb_rd, wb_data    registered destination and result
//   wb_err            illegal operation flag, qualified by wb_valid
//   busy              high whenever not IDLE
//
// state  | meaning
// IDLE   | waiting for in_valid, operands captured on accept
// EXEC   | single-cycle ALU result registered, or divider started
// DIV    | waiting for the divider (exactly N cycles)
// WB     | result presented, held until wb_ready
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int SEL_LINE = SEL_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SEL_LINE-1:0] opcode,
  input  logic [N-1:0]        rs1_val,
  input  logic [N-1:0]        rs2_val,
  input  logic [3:0]          rd_addr,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [3:0]          wb_rd,
  output logic [N-1:0]        wb_data,
  output logic                wb_err,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [SEL_LINE-1:0] op_q, op_d;
  logic [N-1:0]        a_q, a_d, b_q, b_d;
  logic [3:0]          rd_q, rd_d;
  logic [N-1:0]        wb_data_q, wb_data_d;
  logic [3:0]          wb_rd_q, wb_rd_d;
  logic                wb_err_q, wb_err_d;

  logic [N-1:0]        alu_res;
  logic                alu_legal;

`ifdef ALU_DIV_EN
  logic                div_start;
  logic                div_done;
  logic [N-1:0]        div_quotient;

  alu_div_iter #(.N(N)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (a_q),
    .divisor  (b_q),
    .done     (div_done),
    .quotient (div_quotient)
  );
`endif

  // Single-cycle datapath; divide is not handled here and reads as illegal.
  always_comb begin
    alu_res   = '0;
    alu_legal = 1'b1;
    case (op_q)
      SEL_LINE'(OP_ADD): alu_res = a_q + b_q;
      SEL_LINE'(OP_SUB): alu_res = a_q - b_q;
      SEL_LINE'(OP_MUL): alu_res = a_q * b_q;
      SEL_LINE'(OP_AND): alu_res = a_q & b_q;
      SEL_LINE'(OP_OR):  alu_res = a_q | b_q;
      SEL_LINE'(OP_XOR): alu_res = a_q ^ b_q;
      default:           alu_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    rd_d      = rd_q;
    wb_data_d = wb_data_q;
    wb_rd_d   = wb_rd_q;
    wb_err_d  = wb_err_q;
`ifdef ALU_DIV_EN
    div_start = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = opcode;
          a_d     = rs1_val;
          b_d     = rs2_val;
          rd_d    = rd_addr;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        wb_rd_d = rd_q;
`ifdef ALU_DIV_EN
        if (op_q == SEL_LINE'(OP_DIV)) begin
          div_start = 1'b1;
          wb_err_d  = 1'b0;
          state_d   = S_DIV;
        end else
`endif
        begin
          // alu_res is already zero for illegal opcodes
          wb_data_d = alu_res;
          wb_err_d  = !alu_legal;
          state_d   = S_WB;
        end
      end
      S_DIV: begin
`ifdef ALU_DIV_EN
        if (div_done) begin
          wb_data_d = div_quotient;
          state_d   = S_WB;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_WB: begin
        if (wb_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rd_q      <= rd_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      wb_err_q  <= wb_err_d;
    end
  end

  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign wb_valid = (state_q == S_WB);
  assign wb_data  = wb_data_q;
  assign wb_rd    = wb_rd_q;
  assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        wb_ready = 1'b0;
  logic [3:0]  opcode = '0;
  logic [3:0]  rd_addr = '0;
  logic [15:0] rs1_val = '0;
  logic [15:0] rs2_val = '0;
  logic        in_ready, wb_valid, wb_err, busy;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;

  int checks = 0;
  int failures = 0;

  alu_issue_ctrl #(.N(16), .SEL_LINE(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .rs1_val  (rs1_val),
    .rs2_val  (rs2_val),
    .rd_addr  (rd_addr),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .wb_err   (wb_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: result, error flag and latency (cycles from accept edge).
  function automatic void model(input int op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] d, output logic e, output int lat);
    d = '0;
    e = 1'b0;
    lat = 2;
    case (op)
      0: d = a + b;
      1: d = a - b;
      2: d = a * b;
      3: begin
`ifdef ALU_DIV_EN
        d = (b == 16'd0) ? 16'hFFFF : a / b;
        lat = N + 2;
`else
        e = 1'b1;
`endif
      end
      4: d = a & b;
      5: d = a | b;
      6: d = a ^ b;
      default: e = 1'b1;
    endcase
  endfunction

  task automatic run_op(input int op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] rd, input int hold);
    logic [15:0] d;
    logic        e;
    int          lat;
    int          n;
    model(op, a, b, d, e, lat);
    @(negedge clk);
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    opcode   = op[3:0];
    rs1_val  = a;
    rs2_val  = b;
    rd_addr  = rd;
    @(posedge clk);
    #1;
    // inputs scrambled after accept must not matter
    in_valid = 1'($urandom);
    opcode   = 4'($urandom);
    rs1_val  = 16'($urandom);
    rs2_val  = 16'($urandom);
    rd_addr  = 4'($urandom);
    chk("busy_after_accept", {30'd0, in_ready, busy}, 32'd1);
    n = 0;
    while (!wb_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n + 1, lat);
    chk("wb_data", {16'd0, wb_data}, {16'd0, d});
    chk("wb_rd", {28'd0, wb_rd}, {28'd0, rd});
    chk("wb_err", {31'd0, wb_err}, {31'd0, e});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom);
      chk("hold_stable", {8'd0, wb_valid, in_ready, busy, wb_err, wb_rd, wb_data},
          {8'd0, 1'b1, 1'b0, 1'b1, e, rd, d});
    end
    in_valid = 1'b0;
    wb_ready = 1'b1;
    @(posedge clk);
    #1;
    wb_ready = 1'b0;
    chk("idle_after_wb", {29'd0, in_ready, busy, wb_valid}, 32'd4);
  endtask

  initial begin
    int          op;
    logic [15:0] a, b;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {8'd0, wb_valid, busy, wb_err, wb_rd, wb_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    run_op(0, 16'hFFFF, 16'h0001, 4'd1, 0);
    run_op(1, 16'h0003, 16'h0005, 4'd2, 1);
    run_op(2, 16'h0100, 16'h0100, 4'd3, 0);
    run_op(6, 16'hA5A5, 16'hFFFF, 4'd4, 2);
    run_op(3, 16'h0064, 16'h0007, 4'd6, 0);
    run_op(3, 16'h1234, 16'h0000, 4'd7, 1);
    run_op(15, 16'h1111, 16'h2222, 4'd5, 0);
    run_op(4, 16'hF0F0, 16'h3C3C, 4'd8, 10);
    run_op(5, 16'h0F00, 16'h00F0, 4'd9, 0);

    // Reset in the middle of an operation aborts it.
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = 4'd3;
    rs1_val  = 16'h0064;
    rs2_val  = 16'h0007;
    rd_addr  = 4'd10;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
`ifdef ALU_DIV_EN
    repeat (5) @(posedge clk);
    #1;
`endif
    chk("busy_before_abort", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_outputs", {8'd0, in_ready, wb_valid, busy, wb_err, wb_rd, wb_data},
        32'h0080_0000);
    begin
      int seen = 0;
      for (int i = 0; i < N + 6; i++) begin
        @(posedge clk);
        #1;
        if (wb_valid || busy) seen++;
      end
      chk("no_wb_after_abort", seen, 0);
    end
    run_op(0, 16'h0002, 16'h0003, 4'd11, 0);

    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 6));
      a  = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 20));
        default: b = 16'($urandom);
      endcase
      run_op(op, a, b, 4'($urandom), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
